// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mips_pkg                                             |
// | Description : Opcode/funct constants, ALU op enum and ID control   |
// |               bundle shared by the IF/ID decode stage.             |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0A;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_xori  = 6'h0E;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  // R-type funct codes (instr[5:0]); add..nor form a contiguous block
  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_srl  = 6'h02;
  localparam logic [5:0] c_fn_jr   = 6'h08;
  localparam logic [5:0] c_fn_add  = 6'h20;
  localparam logic [5:0] c_fn_nor  = 6'h27;
  localparam logic [5:0] c_fn_slt  = 6'h2A;
  localparam logic [5:0] c_fn_sltu = 6'h2B;

  typedef enum logic [2:0] {
    ALU_FUNCT = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_SLT   = 3'd6,
    ALU_LUI   = 3'd7
  } alu_op_e;

  // ID-stage control bundle; logic_ext travels with it so one gate clears all
  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    logic    jal;
    logic    jump_reg;
    logic    logic_ext;
  } ctrl_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    return fn inside {c_fn_sll, c_fn_srl, c_fn_jr, [c_fn_add:c_fn_nor],
                      c_fn_slt, c_fn_sltu};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_decode_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : if_id_decode_stage_if                                |
// | Description : Fetch-side inputs, hazard controls and decoded ID    |
// |               outputs of the IF/ID decode stage.                   |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface if_id_decode_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] instr_i;
  logic [DATA_WIDTH-1:0] pc_plus4_i;
  logic                  valid_i;
  logic                  stall_i;
  logic                  flush_i;

  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] pc_plus4_o;
  logic                  valid_o;
  logic [4:0]            rs_o;
  logic [4:0]            rt_o;
  logic [4:0]            rd_o;
  logic [15:0]           imm_o;
  logic                  logic_ext_o;
  alu_op_e               alu_op_o;
  logic                  reg_dst_o;
  logic                  alu_src_o;
  logic                  mem_read_o;
  logic                  mem_write_o;
  logic                  mem_to_reg_o;
  logic                  reg_write_o;
  logic                  branch_eq_o;
  logic                  branch_ne_o;
  logic                  jump_o;
  logic                  jal_o;
  logic                  jump_reg_o;
  logic                  illegal_o;

  // The stage itself
  modport slave (
    input  instr_i, pc_plus4_i, valid_i, stall_i, flush_i,
    output instr_o, pc_plus4_o, valid_o, rs_o, rt_o, rd_o, imm_o,
           logic_ext_o, alu_op_o, reg_dst_o, alu_src_o, mem_read_o,
           mem_write_o, mem_to_reg_o, reg_write_o, branch_eq_o,
           branch_ne_o, jump_o, jal_o, jump_reg_o, illegal_o
  );

  // Fetch/hazard driver and ID consumer
  modport master (
    output instr_i, pc_plus4_i, valid_i, stall_i, flush_i,
    input  instr_o, pc_plus4_o, valid_o, rs_o, rt_o, rd_o, imm_o,
           logic_ext_o, alu_op_o, reg_dst_o, alu_src_o, mem_read_o,
           mem_write_o, mem_to_reg_o, reg_write_o, branch_eq_o,
           branch_ne_o, jump_o, jal_o, jump_reg_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/mips_control_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mips_control_decode                                  |
// | Description : Purely combinational opcode/funct main decoder.      |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module mips_control_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode/funct to control bundle; unknown encodings leave controls at 0
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (opcode)
      c_op_rtype: begin
        if (funct == c_fn_jr) begin
          ctrl.jump_reg = 1'b1;
        end else begin
          ctrl.reg_dst = 1'b1;
          ctrl.alu_op  = ALU_FUNCT;
          if (funct_legal(funct)) ctrl.reg_write = 1'b1;
          else                    illegal        = 1'b1;
        end
      end
      c_op_addi, c_op_addiu: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      c_op_slti: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      c_op_andi, c_op_ori, c_op_xori, c_op_lui: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.logic_ext = 1'b1;
        ctrl.alu_op    = (opcode == c_op_andi) ? ALU_AND :
                         (opcode == c_op_ori)  ? ALU_OR  :
                         (opcode == c_op_xori) ? ALU_XOR : ALU_LUI;
      end
      c_op_lw: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      c_op_sw: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      c_op_beq: begin
        ctrl.branch_eq = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      c_op_bne: begin
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALU_SUB;
      end
      c_op_j: begin
        ctrl.jump = 1'b1;
      end
      c_op_jal: begin
        ctrl.jump      = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/if_id_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : if_id_decode_stage                                   |
// | Description : IF/ID pipeline register with stall/flush control and |
// |               valid-gated main control decode of the held word.    |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module if_id_decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
)(
  input  logic                 clk,
  input  logic                 reset,
  if_id_decode_stage_if.slave  bus
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc_plus4;
  logic                  r_valid;
  ctrl_t                 w_dec_ctrl;
  logic                  w_dec_illegal;
  ctrl_t                 w_ctrl;

  // IF/ID register: reset > flush (bubble, PC kept) > stall (hold) > load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (bus.flush_i) begin
      r_instr    <= '0;
      r_valid    <= 1'b0;
    end else if (!bus.stall_i) begin
      r_instr    <= bus.instr_i;
      r_pc_plus4 <= bus.pc_plus4_i;
      r_valid    <= bus.valid_i;
    end
  end

  mips_control_decode u_decode (
    .opcode  (r_instr[31:26]),
    .funct   (r_instr[5:0]),
    .ctrl    (w_dec_ctrl),
    .illegal (w_dec_illegal)
  );

  // An empty slot must not fire any control, extend select or illegal flag
  always_comb begin
    w_ctrl = r_valid ? w_dec_ctrl : '0;
  end

  assign bus.instr_o      = r_instr;
  assign bus.pc_plus4_o   = r_pc_plus4;
  assign bus.valid_o      = r_valid;
  assign bus.rs_o         = r_instr[25:21];
  assign bus.rt_o         = r_instr[20:16];
  assign bus.rd_o         = r_instr[15:11];
  assign bus.imm_o        = r_instr[15:0];
  assign bus.logic_ext_o  = w_ctrl.logic_ext;
  assign bus.alu_op_o     = w_ctrl.alu_op;
  assign bus.reg_dst_o    = w_ctrl.reg_dst;
  assign bus.alu_src_o    = w_ctrl.alu_src;
  assign bus.mem_read_o   = w_ctrl.mem_read;
  assign bus.mem_write_o  = w_ctrl.mem_write;
  assign bus.mem_to_reg_o = w_ctrl.mem_to_reg;
  assign bus.reg_write_o  = w_ctrl.reg_write;
  assign bus.branch_eq_o  = w_ctrl.branch_eq;
  assign bus.branch_ne_o  = w_ctrl.branch_ne;
  assign bus.jump_o       = w_ctrl.jump;
  assign bus.jal_o        = w_ctrl.jal;
  assign bus.jump_reg_o   = w_ctrl.jump_reg;
  assign bus.illegal_o    = r_valid & w_dec_illegal;

endmodule
`default_nettype wire

// File: tb/tb_if_id_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_if_id_decode_stage                                |
// | Description : Self-checking bench for the IF/ID decode stage.      |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_if_id_decode_stage;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  if_id_decode_stage_if #(.DATA_WIDTH(32)) bus ();

  if_id_decode_stage #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference register state
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;

  // Observed outputs packed in a fixed order
  logic [111:0] obs;
  assign obs = {bus.instr_o, bus.pc_plus4_o, bus.valid_o, bus.rs_o, bus.rt_o,
                bus.rd_o, bus.imm_o, bus.alu_op_o, bus.reg_dst_o, bus.alu_src_o,
                bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o,
                bus.reg_write_o, bus.branch_eq_o, bus.branch_ne_o, bus.jump_o,
                bus.jal_o, bus.jump_reg_o, bus.logic_ext_o, bus.illegal_o};

  // Expected decode from the instruction-set rules:
  // {alu(3), reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write,
  //  beq, bne, jump, jal, jump_reg, logic_ext, illegal}
  function automatic logic [15:0] exp_ctrl(input logic [31:0] ins, input logic v);
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] alu;
    logic rd_, as, mr, mw, m2r, rw, be, bn, j, jl, jr, lx, ill;
    op = ins[31:26];
    fn = ins[5:0];
    alu = 3'd0;
    {rd_, as, mr, mw, m2r, rw, be, bn, j, jl, jr, lx, ill} = '0;
    if (!v) return 16'h0;
    case (op)
      6'h00: begin
        if (fn == 6'h08) jr = 1;
        else begin
          rd_ = 1;
          if (fn == 6'h00 || fn == 6'h02 || (fn >= 6'h20 && fn <= 6'h27) ||
              fn == 6'h2A || fn == 6'h2B) rw = 1;
          else ill = 1;
        end
      end
      6'h08, 6'h09: begin as = 1; rw = 1; alu = 3'd1; end
      6'h0A:        begin as = 1; rw = 1; alu = 3'd6; end
      6'h0C:        begin as = 1; rw = 1; alu = 3'd3; lx = 1; end
      6'h0D:        begin as = 1; rw = 1; alu = 3'd4; lx = 1; end
      6'h0E:        begin as = 1; rw = 1; alu = 3'd5; lx = 1; end
      6'h0F:        begin as = 1; rw = 1; alu = 3'd7; lx = 1; end
      6'h23:        begin as = 1; mr = 1; m2r = 1; rw = 1; alu = 3'd1; end
      6'h2B:        begin as = 1; mw = 1; alu = 3'd1; end
      6'h04:        begin be = 1; alu = 3'd2; end
      6'h05:        begin bn = 1; alu = 3'd2; end
      6'h02:        begin j = 1; end
      6'h03:        begin j = 1; jl = 1; rw = 1; end
      default:      ill = 1;
    endcase
    return {alu, rd_, as, mr, mw, m2r, rw, be, bn, j, jl, jr, lx, ill};
  endfunction

  function automatic logic [111:0] exp_obs();
    return {m_instr, m_pc, m_valid, m_instr[25:21], m_instr[20:16],
            m_instr[15:11], m_instr[15:0], exp_ctrl(m_instr, m_valid)};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic v, input logic st, input logic fl,
                       input logic rs);
    bus.instr_i    = ins;
    bus.pc_plus4_i = pc;
    bus.valid_i    = v;
    bus.stall_i    = st;
    bus.flush_i    = fl;
    reset          = rs;
  endtask

  // Advance the reference by the update rule, then clock the DUT
  task automatic cycle();
    if (reset) begin
      m_instr = '0; m_pc = '0; m_valid = 1'b0;
    end else if (bus.flush_i) begin
      m_instr = '0; m_valid = 1'b0;
    end else if (!bus.stall_i) begin
      m_instr = bus.instr_i; m_pc = bus.pc_plus4_i; m_valid = bus.valid_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(32'hFFFF_FFFF, 32'h1234_5678, 1, 0, 0, 1);
    cycle();
    cycle();
    n_checks++;
    if (obs !== 112'h0) $display("FAIL reset_state: got %h expected 0", obs);
    else n_pass++;
  endtask

  task automatic test_andi();
    drive(32'h3128_8000, 32'h0000_0004, 1, 0, 0, 0);
    cycle();
    n_checks++;
    if ({bus.imm_o, bus.logic_ext_o, bus.rs_o, bus.rt_o, bus.alu_op_o,
         bus.alu_src_o, bus.reg_write_o} !== {16'h8000, 1'b1, 5'd9, 5'd8, ALU_AND, 1'b1, 1'b1})
      $display("FAIL andi_fields: got imm=%h ext=%b rs=%0d rt=%0d alu=%0d src=%b rw=%b expected 8000 1 9 8 3 1 1",
               bus.imm_o, bus.logic_ext_o, bus.rs_o, bus.rt_o, bus.alu_op_o,
               bus.alu_src_o, bus.reg_write_o);
    else n_pass++;
    n_checks++;
    if (obs !== exp_obs()) $display("FAIL andi_model: got %h expected %h", obs, exp_obs());
    else n_pass++;
  endtask

  task automatic test_addi();
    drive(32'h2128_FFFC, 32'h0000_0008, 1, 0, 0, 0);
    cycle();
    n_checks++;
    if ({bus.logic_ext_o, bus.imm_o, bus.alu_op_o} !== {1'b0, 16'hFFFC, ALU_ADD})
      $display("FAIL addi_fields: got ext=%b imm=%h alu=%0d expected 0 fffc 1",
               bus.logic_ext_o, bus.imm_o, bus.alu_op_o);
    else n_pass++;
  endtask

  task automatic test_stall();
    drive(32'h8FA8_0004, 32'h0000_0100, 1, 0, 0, 0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(32'h2128_0000 + i, 32'h0000_0200 + i, 1, 1, 0, 0);
      cycle();
      n_checks++;
      if ({bus.instr_o, bus.pc_plus4_o, bus.mem_read_o, bus.mem_to_reg_o, bus.rs_o} !==
          {32'h8FA8_0004, 32'h0000_0100, 1'b1, 1'b1, 5'd29})
        $display("FAIL stall_hold%0d: got instr=%h pc=%h mr=%b m2r=%b rs=%0d expected 8fa80004 100 1 1 29",
                 i, bus.instr_o, bus.pc_plus4_o, bus.mem_read_o, bus.mem_to_reg_o, bus.rs_o);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    drive(32'h1109_0003, 32'h0000_0200, 1, 0, 0, 0);
    cycle();
    n_checks++;
    if ({bus.branch_eq_o, bus.alu_op_o} !== {1'b1, ALU_SUB})
      $display("FAIL beq_decode: got beq=%b alu=%0d expected 1 2", bus.branch_eq_o, bus.alu_op_o);
    else n_pass++;
    drive(32'h1109_0003, 32'h0000_0300, 1, 1, 1, 0);
    cycle();
    n_checks++;
    if (obs !== {32'h0, 32'h0000_0200, 1'b0, 47'h0})
      $display("FAIL flush_bubble: got %h expected %h", obs, {32'h0, 32'h0000_0200, 1'b0, 47'h0});
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'hFC00_0000;
    words[1] = 32'h0000_003F;
    for (int i = 0; i < 2; i++) begin
      drive(words[i], 32'h0000_0400, 1, 0, 0, 0);
      cycle();
      n_checks++;
      if ({bus.illegal_o, bus.reg_write_o} !== 2'b10)
        $display("FAIL illegal_valid%0d: got ill=%b rw=%b expected 1 0", i, bus.illegal_o, bus.reg_write_o);
      else n_pass++;
      drive(words[i], 32'h0000_0400, 0, 0, 0, 0);
      cycle();
      n_checks++;
      if ({bus.illegal_o, bus.reg_write_o} !== 2'b00)
        $display("FAIL illegal_invalid%0d: got ill=%b rw=%b expected 0 0", i, bus.illegal_o, bus.reg_write_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h0C00_0010, 32'h0000_0500, 1, 0, 0, 0);
    cycle();
    n_checks++;
    if ({bus.jump_o, bus.jal_o, bus.reg_write_o} !== 3'b111)
      $display("FAIL jal_decode: got j=%b jal=%b rw=%b expected 1 1 1", bus.jump_o, bus.jal_o, bus.reg_write_o);
    else n_pass++;
    drive(32'h2128_0001, 32'h0000_0600, 1, 1, 0, 1);
    cycle();
    n_checks++;
    if (obs !== 112'h0) $display("FAIL reset_mid_stall: got %h expected 0", obs);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ops [14];
    logic [5:0] fns [15];
    logic [31:0] ins;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    fns = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h01};
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[31:26] = ops[$urandom_range(0, 13)];
      if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 14)];
      drive(ins, $urandom, ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 39) == 0));
      cycle();
      n_checks++;
      if (obs !== exp_obs()) $display("FAIL random%0d: got %h expected %h", n, obs, exp_obs());
      else n_pass++;
    end
  endtask

  initial begin
    m_instr = '0; m_pc = '0; m_valid = 1'b0;
    drive(32'h0, 32'h0, 0, 0, 0, 1);
    test_reset();
    test_andi();
    test_addi();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_decode_stage.md
# if_id_decode_stage

Registered IF/ID boundary plus main control decoder for the pipelined MIPS core. It sits between instruction fetch and the sign-extend/register-file stage. It captures the fetched instruction and PC+4 under stall/flush control from the hazard unit. From the held instruction it produces the 16-bit immediate, the `logic_ext` select that drives zero- vs sign-extension, register addresses, and the ID-stage control bundle.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction and PC width.

Ports (`clk` is the only clock; `reset` is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `instr_i`  in  32  fetched instruction.
- `pc_plus4_i`  in  32  PC+4 of the fetched instruction.
- `valid_i`  in  1  fetch output is a real instruction.
- `stall_i`  in  1  hold the current register contents (load-use hazard).
- `flush_i`  in  1  replace the register contents with a bubble (taken branch/jump).
- `instr_o`  out  32  held instruction.
- `pc_plus4_o`  out  32  held PC+4.
- `valid_o`  out  1  held slot is a real instruction.
- `rs_o`, `rt_o`, `rd_o`  out  5 each  instr[25:21], instr[20:16], instr[15:11].
- `imm_o`  out  16  instr[15:0]; feeds the extender data input.
- `logic_ext_o`  out  1  1 selects zero-extend, 0 selects sign-extend.
- `alu_op_o`  out  3  ALU operation class (package enum).
- `reg_dst_o`, `alu_src_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`, `reg_write_o`  out  1 each  standard control bits.
- `branch_eq_o`, `branch_ne_o`, `jump_o`, `jal_o`, `jump_reg_o`  out  1 each  control-flow controls.
- `illegal_o`  out  1  valid slot holds an unrecognised opcode or funct.

## Operation
- Register update priority on each edge: `reset`, then `flush_i`, then `stall_i`, then load.
  - `reset`: `instr` is 0, `pc_plus4` is 0, `valid` is 0.
  - `flush_i`: `instr` is 0 (NOP), `valid` is 0, `pc_plus4` is unchanged.
  - `stall_i`: all fields hold.
  - Load: `instr` ← `instr_i`, `pc_plus4` ← `pc_plus4_i`, `valid` ← `valid_i`.
- Decode is combinational from the held instruction. When `valid_o` is 0, every control output, `logic_ext_o` and `illegal_o` is forced to 0. Field outputs pass through unchanged.
- Opcode decode:
  - R-type, 0x00: `reg_dst`, `reg_write`, `alu_op`=FUNCT.
  - R-type with funct 0x08 (jr): `jump_reg` only; `reg_write` is 0.
  - addi 0x08 and addiu 0x09: `alu_src`, `reg_write`, ADD, sign-extend.
  - slti 0x0A: `alu_src`, `reg_write`, SLT, sign-extend.
  - andi 0x0C, ori 0x0D, xori 0x0E: `alu_src`, `reg_write`, AND/OR/XOR, `logic_ext`=1.
  - lui 0x0F: `alu_src`, `reg_write`, LUI, `logic_ext`=1.
  - lw 0x23: `alu_src`, `mem_read`, `mem_to_reg`, `reg_write`, ADD, sign-extend.
  - sw 0x2B: `alu_src`, `mem_write`, ADD, sign-extend.
  - beq 0x04 and bne 0x05: `branch_eq` or `branch_ne` respectively, SUB, sign-extend.
  - j 0x02: `jump`.
  - jal 0x03: `jump`, `jal`, `reg_write`.
  - Any other opcode: all controls 0, `illegal_o`=1.
- R-type funct values recognised: 0x00, 0x02, 0x08, 0x20–0x27, 0x2A, 0x2B. Any other funct sets `illegal_o`=1 and forces `reg_write` to 0.
- The all-zero NOP decodes as sll $0,$0,0 and is legal.

## Timing
- Latency is 1 cycle from `instr_i` to `instr_o` and the decoded outputs. There is no combinational path from `instr_i` to any output.
- Stall or flush applies on the edge at which it is sampled. A flush asserted together with a stall produces a bubble.
- Reset asserted mid-stream clears the register on the next edge, regardless of `stall_i` or `flush_i`.
- Reset value of every output is 0.
- Back-to-back loads with no stall give a throughput of one instruction per cycle.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct constants;
  - the `alu_op` enum: FUNCT=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLT=6, LUI=7;
  - the control-bundle struct.
- Sub-module `mips_control_decode` contains the purely combinational opcode/funct decoder.
- The top module holds the IF/ID register and the valid gating.

## Test plan
- Reset, then load 0x31288000 (andi $t0,$t1,0x8000) with `valid_i`=1 → next cycle: `imm_o`=0x8000, `logic_ext_o`=1, `rs_o`=9, `rt_o`=8, `alu_op`=AND, `alu_src`=1, `reg_write`=1.
- Load 0x2128FFFC (addi $t0,$t1,-4) → `logic_ext_o`=0, `imm_o`=0xFFFC, `alu_op`=ADD.
- Load 0x8FA80004 (lw), then hold `stall_i`=1 for 2 cycles while `instr_i` changes → outputs stay at lw for those 2 cycles: `mem_read`=1, `mem_to_reg`=1, `rs_o`=29.
- Assert `flush_i` and `stall_i` together while holding a beq → next cycle `instr_o`=0, `valid_o`=0, all controls 0, `pc_plus4_o` unchanged.
- Load opcode 0x3F, then R-type with funct 0x3F → `illegal_o`=1 in both cases with `reg_write`=0. With `valid_i`=0 the same words give `illegal_o`=0.
- Assert `reset` mid-stall → next edge: `instr_o`=0, `pc_plus4_o`=0, `valid_o`=0.
